// File: rtl/regfile_cells.sv
// regfile_cells -- 8 x 16-bit register file built from leaf cells.
//
// Leaf cells (all in this file):
//   dfrl      1-bit register, synchronous active-high reset, load enable
//   demux8    1-to-8 enable decoder, o[k] = i when {j2,j1,j0} == k
//   mux8      8-to-1 bit selector, o = i[{j2,j1,j0}]
// Composites:
//   reg16     16 dfrl cells sharing one load
//   mux128_16 16 mux8 cells: one 16-bit read port over 8 registers
//   reg_file  demux8 write decode + 8 reg16 + two mux128_16 read ports
//
// Top ports (regfile_cells):
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high clear of all registers
//   wr         in   write strobe; register wr_addr loads wr_data at the edge
//   wr_addr    in   [2:0] write register index
//   wr_data    in   [15:0] write data
//   rd_addr_a  in   [2:0] read port A index
//   rd_addr_b  in   [2:0] read port B index
//   rd_data_a  out  [15:0] combinational read data, port A
//   rd_data_b  out  [15:0] combinational read data, port B
//
// The cells have no handshake: writes are single-cycle strobes and reads
// are purely combinational, so new data is visible right after the edge
// that sampled wr=1.

module dfrl (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic in,
  output logic out
);
  logic out_d;
  logic out_q;

  always_comb begin
    out_d = out_q;
    if (load) out_d = in;
  end

  // Reset wins over load when both are high on the same edge.
  always_ff @(posedge clk) begin
    if (reset) out_q <= 1'b0;
    else       out_q <= out_d;
  end

  assign out = out_q;
endmodule

module demux8 (
  input  logic       i,
  input  logic       j2,
  input  logic       j1,
  input  logic       j0,
  output logic [0:7] o
);
  // AND of the enable with a minterm decode: when i is 0 every output is a
  // hard 0 even if the select bits are unknown, so a disabled write can
  // never reach a register load.
  for (genvar k = 0; k < 8; k++) begin : g_dec
    localparam logic [2:0] SEL = 3'(k);
    assign o[k] = i & (j2 ~^ SEL[2]) & (j1 ~^ SEL[1]) & (j0 ~^ SEL[0]);
  end
endmodule

module mux8 (
  input  logic [0:7] i,
  input  logic       j2,
  input  logic       j1,
  input  logic       j0,
  output logic       o
);
  // Three levels of 2:1 muxes: j0 picks within pairs, j1 within quads,
  // j2 between halves.
  logic [0:3] lvl1;
  logic [0:1] lvl2;

  assign lvl1[0] = j0 ? i[1] : i[0];
  assign lvl1[1] = j0 ? i[3] : i[2];
  assign lvl1[2] = j0 ? i[5] : i[4];
  assign lvl1[3] = j0 ? i[7] : i[6];
  assign lvl2[0] = j1 ? lvl1[1] : lvl1[0];
  assign lvl2[1] = j1 ? lvl1[3] : lvl1[2];
  assign o       = j2 ? lvl2[1] : lvl2[0];
endmodule

module reg16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] d,
  output logic [15:0] q
);
  for (genvar b = 0; b < 16; b++) begin : g_bit
    dfrl u_cell (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .in    (d[b]),
      .out   (q[b])
    );
  end
endmodule

module mux128_16 (
  input  logic [127:0] regs,   // register k occupies regs[16*k +: 16]
  input  logic [2:0]   sel,
  output logic [15:0]  o
);
  for (genvar b = 0; b < 16; b++) begin : g_bit
    // Gather bit b of every register; register k lands at column index k.
    logic [0:7] col;
    for (genvar k = 0; k < 8; k++) begin : g_col
      assign col[k] = regs[16*k + b];
    end
    mux8 u_mux (
      .i  (col),
      .j2 (sel[2]),
      .j1 (sel[1]),
      .j0 (sel[0]),
      .o  (o[b])
    );
  end
endmodule

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr_a,
  input  logic [2:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b
);
  logic [0:7]   load;
  logic [127:0] regs;

  demux8 u_wr_dec (
    .i  (wr),
    .j2 (wr_addr[2]),
    .j1 (wr_addr[1]),
    .j0 (wr_addr[0]),
    .o  (load)
  );

  for (genvar k = 0; k < 8; k++) begin : g_reg
    reg16 u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .d     (wr_data),
      .q     (regs[16*k +: 16])
    );
  end

  mux128_16 u_rd_a (
    .regs (regs),
    .sel  (rd_addr_a),
    .o    (rd_data_a)
  );

  mux128_16 u_rd_b (
    .regs (regs),
    .sel  (rd_addr_b),
    .o    (rd_data_b)
  );
endmodule

module regfile_cells (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr_a,
  input  logic [2:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b
);
  reg_file u_rf (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );
endmodule

// File: tb/tb_regfile_cells.sv
// tb_regfile_cells -- directed bench for the register file and its leaf
// cells. Expected values are pushed to exp_q when stimulus is applied and
// popped when the corresponding output is sampled.

module tb_regfile_cells;
  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT: register file ----------------
  logic        wr;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;

  regfile_cells u_dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  // ---------------- leaf cells ----------------
  logic       l_reset, l_load, l_in, l_out;
  logic       dm_i, dm_j2, dm_j1, dm_j0;
  logic [0:7] dm_o;
  logic [0:7] mx_i;
  logic       mx_j2, mx_j1, mx_j0, mx_o;

  dfrl u_dfrl (
    .clk   (clk),
    .reset (l_reset),
    .load  (l_load),
    .in    (l_in),
    .out   (l_out)
  );

  demux8 u_demux (
    .i  (dm_i),
    .j2 (dm_j2),
    .j1 (dm_j1),
    .j0 (dm_j0),
    .o  (dm_o)
  );

  mux8 u_mux (
    .i  (mx_i),
    .j2 (mx_j2),
    .j1 (mx_j1),
    .j0 (mx_j0),
    .o  (mx_o)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] model [8];
  int total = 0;
  int bad   = 0;

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_val(input logic [15:0] obs);
    logic [15:0] exp;
    string       tag;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rf_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    wr      = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr      = 1'b0;
    model[a] = d;
  endtask

  task automatic rf_read(input string tag, input logic [2:0] a, input logic [2:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    expect_val({tag, "_a"}, model[a]);
    expect_val({tag, "_b"}, model[b]);
    #1;
    check_val(rd_data_a);
    check_val(rd_data_b);
  endtask

  task automatic rf_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b0;
    wr        = 1'b0;
    wr_addr   = 3'd0;
    wr_data   = 16'h0000;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    l_reset   = 1'b0;
    l_load    = 1'b0;
    l_in      = 1'b0;
    dm_i = 1'b0; dm_j2 = 1'b0; dm_j1 = 1'b0; dm_j0 = 1'b0;
    mx_i = 8'h00; mx_j2 = 1'b0; mx_j1 = 1'b0; mx_j0 = 1'b0;

    // dfrl: reset, load 1, hold, reset beats load
    @(negedge clk);
    l_reset = 1'b1;
    expect_val("dfrl_reset", 16'd0);
    @(negedge clk);
    check_val({15'd0, l_out});
    l_reset = 1'b0; l_load = 1'b1; l_in = 1'b1;
    expect_val("dfrl_load1", 16'd1);
    @(negedge clk);
    check_val({15'd0, l_out});
    l_load = 1'b0; l_in = 1'b0;
    expect_val("dfrl_hold", 16'd1);
    @(negedge clk);
    check_val({15'd0, l_out});
    l_reset = 1'b1; l_load = 1'b1; l_in = 1'b1;
    expect_val("dfrl_reset_over_load", 16'd0);
    @(negedge clk);
    check_val({15'd0, l_out});
    l_reset = 1'b0; l_load = 1'b1; l_in = 1'b1;
    expect_val("dfrl_reload", 16'd1);
    @(negedge clk);
    check_val({15'd0, l_out});
    l_load = 1'b0;

    // demux8: enable 1, sweep every select value
    dm_i = 1'b1;
    for (int s = 0; s < 8; s++) begin
      logic [2:0] sv;
      logic [7:0] one_hot;
      sv = 3'(s);
      {dm_j2, dm_j1, dm_j0} = sv;
      one_hot = 8'h80 >> s;      // bit 7 of the vector maps to o[0]
      expect_val($sformatf("demux_sel%0d", s), {8'h00, one_hot});
      #1;
      check_val({8'h00, dm_o});
    end
    // demux8: enable 0 with unknown selects gives all zeros
    dm_i = 1'b0;
    dm_j2 = 1'bx; dm_j1 = 1'bx; dm_j0 = 1'bx;
    expect_val("demux_off_selx", 16'h0000);
    #1;
    check_val({8'h00, dm_o});
    // sel=3 with enable: o as [0:7] = {0,0,0,1,0,0,0,0}
    dm_i = 1'b1;
    {dm_j2, dm_j1, dm_j0} = 3'd3;
    expect_val("demux_sel3_pattern", 16'h0010);
    #1;
    check_val({8'h00, dm_o});

    // mux8: walking one through every position, sweep every select
    for (int p = 0; p < 8; p++) begin
      logic [7:0] pat;
      pat  = 8'h80 >> p;         // position p as [0:7]
      mx_i = pat;
      for (int s = 0; s < 8; s++) begin
        logic [2:0] sv;
        sv = 3'(s);
        {mx_j2, mx_j1, mx_j0} = sv;
        expect_val($sformatf("mux_pos%0d_sel%0d", p, s), (s == p) ? 16'd1 : 16'd0);
        #1;
        check_val({15'd0, mx_o});
      end
    end

    // register file: reset, then every register reads zero
    rf_reset();
    for (int k = 0; k < 8; k++) rf_read($sformatf("rst_r%0d", k), 3'(k), 3'(7 - k));

    // write r3, read same address on both ports
    rf_write(3'd3, 16'hCDEF);
    expect_val("r3_direct_a", 16'hCDEF);
    expect_val("r3_direct_b", 16'hCDEF);
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd3;
    #1;
    check_val(rd_data_a);
    check_val(rd_data_b);

    // write r5, r7 still zero
    rf_write(3'd5, 16'h4567);
    rf_read("r5_r7", 3'd5, 3'd7);

    // write r0, check neighbours
    rf_write(3'd0, 16'hBA98);
    rf_read("r1_r5", 3'd1, 3'd5);
    rf_read("r0_r3", 3'd0, 3'd3);
    expect_val("r0_direct", 16'hBA98);
    #1;
    check_val(rd_data_a);

    // disabled write with unknown address changes nothing
    @(negedge clk);
    wr      = 1'b0;
    wr_addr = 3'bxxx;
    wr_data = 16'h1234;
    @(negedge clk);
    wr_addr = 3'd0;
    for (int k = 0; k < 8; k++) rf_read($sformatf("nowr_r%0d", k), 3'(k), 3'(k));

    // write r7 all ones
    rf_write(3'd7, 16'hFFFF);
    expect_val("r7_direct", 16'hFFFF);
    rd_addr_b = 3'd7;
    #1;
    check_val(rd_data_b);

    // reset together with a write strobe: reset wins
    @(negedge clk);
    reset   = 1'b1;
    wr      = 1'b1;
    wr_addr = 3'd2;
    wr_data = 16'hAAAA;
    @(negedge clk);
    reset = 1'b0;
    wr    = 1'b0;
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
    rf_read("rst_wr_r2_r7", 3'd2, 3'd7);

    // random writes and reads
    for (int n = 0; n < 40; n++) begin
      rf_write(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
      rf_read($sformatf("rand%0d", n), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
